// File: rtl/vx_credit_arbiter_if.sv
// Request/credit bundle between requesters and vx_credit_arbiter.
// The master modport is the requester side; slave is the arbiter.
interface vx_credit_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int CREDITS  = 8
);
  localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNTW = $clog2(CREDITS + 1);

  logic [NUM_REQS-1:0] req_valid;
  logic [NUM_REQS-1:0] req_ready;
  logic                rsp_valid;
  logic [IDXW-1:0]     rsp_idx;
  logic                flush;
  logic                drained;
  logic [CNTW-1:0]     total_used;
  logic                empty;
  logic                full;
  logic                alm_full;
  logic                err;

  modport master (
    output req_valid, rsp_valid, rsp_idx, flush,
    input  req_ready, drained, total_used,
    input  empty, full, alm_full, err
  );

  modport slave (
    input  req_valid, rsp_valid, rsp_idx, flush,
    output req_ready, drained, total_used,
    output empty, full, alm_full, err
  );
endinterface

// File: rtl/vx_credit_arbiter.sv
// Round-robin credit arbiter with flush/drain sequencing.
// CREDIT_ARB_PERREQ_CAP_EN enables per-requester outstanding caps.
module vx_credit_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int CREDITS     = 8,
  parameter int PER_REQ_MAX = 4,
  parameter int ALM_FULL    = CREDITS - 1
) (
  input  logic clk,
  input  logic reset,
  vx_credit_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNTW = $clog2(CREDITS + 1);

  if (NUM_REQS < 2) begin : g_chk_n
    $error("NUM_REQS must be >= 2");
  end
  if (CREDITS < 2) begin : g_chk_c
    $error("CREDITS must be >= 2");
  end
  if (PER_REQ_MAX < 1 || PER_REQ_MAX > CREDITS) begin : g_chk_p
    $error("PER_REQ_MAX out of range");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] total_q, total_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            empty_q, full_q, alm_q;
  logic            drained_q, err_q;

  logic [NUM_REQS-1:0] elig;
  logic [NUM_REQS-1:0] gnt;
  logic                gnt_any;
  logic                idx_ok;
  logic                rsp_ok;

  assign idx_ok = int'(bus.rsp_idx) < NUM_REQS;

`ifdef CREDIT_ARB_PERREQ_CAP_EN
  logic [CNTW-1:0] cnt_q [NUM_REQS];
  logic [CNTW-1:0] cnt_d [NUM_REQS];
  logic            cnt_nz;

  always_comb begin
    cnt_nz = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (IDXW'(i) == bus.rsp_idx) cnt_nz = (cnt_q[i] != '0);
    end
  end

  assign rsp_ok = bus.rsp_valid & idx_ok & cnt_nz;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = bus.req_valid[i] & ~full_q & ~reset
              & (state_q == RUN)
              & (cnt_q[i] < CNTW'(PER_REQ_MAX));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      cnt_d[i] = cnt_q[i] + CNTW'(gnt[i])
               - CNTW'(rsp_ok & (IDXW'(i) == bus.rsp_idx));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign rsp_ok = bus.rsp_valid & idx_ok & ~empty_q;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = bus.req_valid[i] & ~full_q & ~reset
              & (state_q == RUN);
    end
  end
`endif

  // Search from ptr_q, wrapping; the first eligible index wins.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_any = 1'b0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (!gnt_any && elig[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        ptr_d   = (j == NUM_REQS - 1) ? '0 : IDXW'(j + 1);
      end
    end
  end

  assign total_d = total_q + CNTW'(gnt_any) - CNTW'(rsp_ok);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.flush)
                 state_d = (total_d == '0) ? HALT : DRAIN;
      DRAIN:   if (!bus.flush)        state_d = RUN;
               else if (total_d == '0) state_d = HALT;
      HALT:    if (!bus.flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      total_q   <= '0;
      ptr_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      alm_q     <= 1'b0;
      drained_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      ptr_q     <= ptr_d;
      empty_q   <= (total_d == '0);
      full_q    <= (total_d == CNTW'(CREDITS));
      alm_q     <= (total_d >= CNTW'(ALM_FULL));
      drained_q <= (state_d == HALT);
      err_q     <= err_q | (bus.rsp_valid & ~rsp_ok);
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.total_used = total_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.alm_full   = alm_q;
  assign bus.drained    = drained_q;
  assign bus.err        = err_q;
endmodule

// File: doc/vx_credit_arbiter.md
# VX_credit_arbiter

Round-robin arbiter that shares a fixed pool of outstanding-request credits among NUM_REQS requesters in front of a shared memory/execute port. It issues at most one grant per cycle, counts in-flight requests globally and per requester, returns credits on responses, and sequences a flush/drain handshake. It is the control layer on top of the pending-size counters the design already uses for occupancy tracking.

## Interface
- NUM_REQS, 4: number of requesters (≥2)
- CREDITS, 8: global outstanding-request limit (≥2)
- PER_REQ_MAX, 4: per-requester outstanding limit (1..CREDITS); used only with the cap feature
- ALM_FULL, CREDITS-1: total_used threshold for alm_full
- IDXW, LOG2UP(NUM_REQS): requester index width; CNTW, CLOG2(CREDITS+1): counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQS  request pending per requester
- req_ready  out  NUM_REQS  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  in  1  one credit returned this cycle
- rsp_idx  in  IDXW  requester owning the returned credit
- flush  in  1  stop granting and drain outstanding requests
- drained  out  1  flush complete, nothing outstanding
- total_used  out  CNTW  credits in flight
- empty / full / alm_full  out  1  total_used==0 / ==CREDITS / >=ALM_FULL
- err  out  1  sticky: response for requester with zero outstanding

## Operation
- Eligible(i) = req_valid[i] & ~full & state==RUN & (cap feature: cnt[i] < PER_REQ_MAX).
- Round-robin: search starts at pointer ptr; first eligible index (wrapping) gets req_ready. Zero or one bit set.
- On grant to g: ptr <= (g+1) mod NUM_REQS; no grant: ptr holds.
- total_used next = total_used + grant - rsp_ok, where rsp_ok = rsp_valid & (cnt[rsp_idx] != 0) (cap feature) or rsp_valid & ~empty (no cap).
- Grant and release same cycle: total unchanged; same requester: cnt unchanged.
- Invalid release (rsp_valid & ~rsp_ok): ignored, no decrement, err <= 1 until reset.
- rsp_idx >= NUM_REQS: treated as invalid release.
- Credits freed this cycle are not usable until the next cycle (eligibility uses registered counts only).
- FSM:
  - RUN: grants allowed. flush=1 → DRAIN (or HALT if empty).
  - DRAIN: no grants; responses still accepted. empty next cycle → HALT.
  - HALT: drained=1, no grants. flush=0 → RUN.
- flush deasserted while in DRAIN → RUN.
- empty/full/alm_full are registered, computed from next-state total_used.

## Timing
- req_ready is combinational from registered state and current req_valid; no back-pressure path from req_ready to req_valid.
- Counters, flags, ptr, FSM update on the edge after the event; one-cycle latency from grant/response to total_used.
- drained is a registered output, asserted on the cycle the FSM enters HALT.
- Reset (any time, including mid-drain): total_used=0, all cnt=0, empty=1, full=0, alm_full=0, ptr=0, state=RUN, drained=0, err=0, req_ready=0 on the reset cycle. In-flight responses arriving after reset count as invalid releases.

## Configuration
- CREDIT_ARB_PERREQ_CAP_EN defined: per-requester CNTW counters instantiated, PER_REQ_MAX enforced, release validity checked per requester.
- Undefined: no per-requester counters; only full gates eligibility; release is valid whenever ~empty; PER_REQ_MAX is ignored.

## Test plan
- Fairness: NUM_REQS=4, all req_valid=1, no responses → grants 0,1,2,3,0,1,2,3; full=1 after 8th grant, req_ready=0 afterwards.
- Credit return: full, rsp_valid with rsp_idx=2 → total_used 8→7 next cycle, a grant issues one cycle after that, total back to 8.
- Simultaneous: total_used=5, grant and response same cycle → total_used stays 5; empty/full unchanged.
- Cap (macro defined, PER_REQ_MAX=2): only req_valid[1]=1 → two grants, then req_ready[1]=0 while total_used=2 < CREDITS.
- Drain: 3 outstanding, flush=1 → no grants; 3 responses → drained=1 the cycle after the third; flush=0 → grants resume next cycle.
- Error: empty, rsp_valid=1 → total_used stays 0, err=1 and remains set until reset.
